// File: rtl/uart_icb_master.sv
// uart_icb_master
//   Turns byte frames from a UART receiver into single ICB bus transactions
//   and reports the result back through the UART transmitter.
//   Frame: 0x52 (read) or 0x57 (write), 4 address bytes MSB first, then for
//   writes 4 data bytes MSB first. A read answers with the 4 rdata bytes
//   MSB first; a write answers with the single byte 0x4B.
//
//   Optional feature: define UART_ICB_BYTE_TIMEOUT_EN to abandon a frame
//   whose next byte fails to arrive within TIMEOUT_CYC clk cycles while
//   collecting address/data bytes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_byte, rx_valid          received byte + one-cycle strobe (no backpressure)
//   tx_byte, tx_valid, tx_ready  byte towards the transmitter (valid/ready)
//   o_icb_cmd_*                ICB command channel (master side)
//   o_icb_rsp_*                ICB response channel (master side)
//   busy                       a frame is in progress (state not IDLE)
//   frame_err                  one-cycle pulse: bad opcode or byte timeout
//   rx_ovr                     one-cycle pulse: byte dropped while not receiving
module uart_icb_master #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        o_icb_cmd_valid,
  input  logic        o_icb_cmd_ready,
  output logic [31:0] o_icb_cmd_addr,
  output logic        o_icb_cmd_read,
  output logic [31:0] o_icb_cmd_wdata,
  input  logic        o_icb_rsp_valid,
  output logic        o_icb_rsp_ready,
  input  logic [31:0] o_icb_rsp_rdata,
  output logic        busy,
  output logic        frame_err,
  output logic        rx_ovr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_CMD   = 3'd3;
  localparam logic [2:0] S_RSP   = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] WR_ACK   = 8'h4B;

  logic [2:0]  state_reg, state_next;
  logic        read_reg, read_next;
  logic [1:0]  cnt_reg, cnt_next;      // byte index within ADDR/WDATA/TX
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        frame_err_reg, frame_err_next;
  logic        rx_ovr_reg, rx_ovr_next;

`ifdef UART_ICB_BYTE_TIMEOUT_EN
  logic [15:0] tmo_reg, tmo_next;
  logic        collecting;

  assign collecting = (state_reg == S_ADDR) || (state_reg == S_WDATA);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_next     = state_reg;
    read_next      = read_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    frame_err_next = 1'b0;
    rx_ovr_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == OP_READ || rx_byte == OP_WRITE) begin
            read_next  = (rx_byte == OP_READ);
            cnt_next   = 2'd0;
            state_next = S_ADDR;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_next = {addr_reg[23:0], rx_byte};
          cnt_next  = cnt_reg + 2'd1;   // wraps to 0 for the WDATA phase
          if (cnt_reg == 2'd3) state_next = read_reg ? S_CMD : S_WDATA;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          wdata_next = {wdata_reg[23:0], rx_byte};
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (o_icb_cmd_ready) state_next = S_RSP;
      end
      S_RSP: begin
        if (o_icb_rsp_valid) begin
          if (read_reg) rdata_next = o_icb_rsp_rdata;
          cnt_next   = 2'd0;
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (tx_ready) begin
          if (!read_reg || cnt_reg == 2'd3) state_next = S_IDLE;
          else                              cnt_next   = cnt_reg + 2'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Bytes arriving while the bus or transmitter side is active are lost.
    if (rx_valid && (state_reg == S_CMD || state_reg == S_RSP || state_reg == S_TX))
      rx_ovr_next = 1'b1;

`ifdef UART_ICB_BYTE_TIMEOUT_EN
    tmo_next = (rx_valid || !collecting) ? 16'd0 : tmo_reg + 16'd1;
    if (collecting && !rx_valid && tmo_reg == TIMEOUT_CYC - 16'd1) begin
      state_next     = S_IDLE;
      frame_err_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      read_reg      <= 1'b0;
      cnt_reg       <= 2'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rdata_reg     <= 32'd0;
      frame_err_reg <= 1'b0;
      rx_ovr_reg    <= 1'b0;
`ifdef UART_ICB_BYTE_TIMEOUT_EN
      tmo_reg       <= 16'd0;
`endif
    end else begin
      state_reg     <= state_next;
      read_reg      <= read_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      frame_err_reg <= frame_err_next;
      rx_ovr_reg    <= rx_ovr_next;
`ifdef UART_ICB_BYTE_TIMEOUT_EN
      tmo_reg       <= tmo_next;
`endif
    end
  end

  // Reply byte is selected straight from held registers, so it stays
  // stable for as long as the transmitter stalls.
  always_comb begin
    tx_byte = 8'h00;
    if (state_reg == S_TX) begin
      if (!read_reg) begin
        tx_byte = WR_ACK;
      end else begin
        case (cnt_reg)
          2'd0:    tx_byte = rdata_reg[31:24];
          2'd1:    tx_byte = rdata_reg[23:16];
          2'd2:    tx_byte = rdata_reg[15:8];
          default: tx_byte = rdata_reg[7:0];
        endcase
      end
    end
  end

  assign tx_valid        = (state_reg == S_TX);
  assign o_icb_cmd_valid = (state_reg == S_CMD);
  assign o_icb_cmd_addr  = addr_reg;
  assign o_icb_cmd_read  = read_reg;
  assign o_icb_cmd_wdata = read_reg ? 32'd0 : wdata_reg;
  assign o_icb_rsp_ready = (state_reg == S_RSP);
  assign busy            = (state_reg != S_IDLE);
  assign frame_err       = frame_err_reg;
  assign rx_ovr          = rx_ovr_reg;

endmodule

// File: tb/tb_uart_icb_master.sv
// Self-checking bench for uart_icb_master: frame-level model (queues of
// expected commands and expected reply bytes) checked every cycle by one
// monitor, plus literal expectations for the reference frames.
module tb_uart_icb_master;

`ifdef UART_ICB_BYTE_TIMEOUT_EN
  localparam logic [15:0] TB_TMO = 16'd100;
`else
  localparam logic [15:0] TB_TMO = 16'd20000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy, frame_err, rx_ovr;

  always #5 clk = ~clk;

  uart_icb_master #(.TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready),
    .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_read(cmd_read),
    .o_icb_cmd_wdata(cmd_wdata),
    .o_icb_rsp_valid(rsp_valid), .o_icb_rsp_ready(rsp_ready),
    .o_icb_rsp_rdata(rsp_rdata),
    .busy(busy), .frame_err(frame_err), .rx_ovr(rx_ovr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s", name, what);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] got_tx_q[$];
  int exp_ferr = 0, exp_ovr = 0, ferr_seen = 0, ovr_seen = 0;
  logic        last_rd;
  logic [31:0] last_addr, last_wdata;
  int last_cmd_cycles = 0;

  // ---------------- responders ----------------
  int cr_mode = 0;   // 0 random, 1 stall 5 valid cycles, 2 never, 3 always
  int tr_mode = 0;   // 0 random, 1 toggle
  int rv_mode = 0;   // 0 random, 1 withheld
  logic rd_fixed = 1'b0;

  initial begin
    int hold_cnt;
    hold_cnt = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_rdata = 0; tx_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (cr_mode)
        1: begin
          cmd_ready = (hold_cnt >= 5);
          hold_cnt  = cmd_valid ? hold_cnt + 1 : 0;
        end
        2:       cmd_ready = 1'b0;
        3:       cmd_ready = 1'b1;
        default: cmd_ready = ($urandom_range(0, 2) != 0);
      endcase
      tx_ready  = (tr_mode == 1) ? ~tx_ready : 1'($urandom_range(0, 1));
      rsp_valid = (rv_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      rsp_rdata = rd_fixed ? 32'h0000_0011 : $urandom;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_cv, prev_cr, prev_tv, prev_tr, awaiting, cur_rd;
    logic [31:0] prev_addr, prev_wdata;
    logic [7:0]  prev_tb;
    int valid_run;
    cmd_t e;
    logic [7:0] eb;
    prev_cv = 0; prev_cr = 0; prev_tv = 0; prev_tr = 0; awaiting = 0; cur_rd = 0;
    prev_addr = 0; prev_wdata = 0; prev_tb = 0; valid_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cv = 0; prev_tv = 0; awaiting = 0; valid_run = 0;
      end else begin
        chk("rsp_ready_window", 32'(rsp_ready), 32'(awaiting));
        if (prev_cv && !prev_cr) begin
          chk("cmd_valid_hold", 32'(cmd_valid), 32'd1);
          chk("cmd_addr_hold", cmd_addr, prev_addr);
          chk("cmd_wdata_hold", cmd_wdata, prev_wdata);
        end
        if (prev_tv && !prev_tr) begin
          chk("tx_valid_hold", 32'(tx_valid), 32'd1);
          chk("tx_byte_hold", 32'(tx_byte), 32'(prev_tb));
        end
        if (cmd_valid) valid_run++;
        if (cmd_valid && cmd_ready) begin
          $display("cmd addr=%h read=%0d wdata=%h", cmd_addr, cmd_read, cmd_wdata);
          if (exp_cmd_q.size() == 0) begin
            fail("cmd_unexpected", $sformatf("actual addr=%h required=none", cmd_addr));
          end else begin
            e = exp_cmd_q.pop_front();
            chk("cmd_addr", cmd_addr, e.addr);
            chk("cmd_read", 32'(cmd_read), 32'(e.rd));
            chk("cmd_wdata", cmd_wdata, e.rd ? 32'd0 : e.wdata);
            cur_rd = e.rd;
          end
          last_rd = cmd_read; last_addr = cmd_addr; last_wdata = cmd_wdata;
          last_cmd_cycles = valid_run;
          valid_run = 0;
          awaiting = 1;
        end
        if (rsp_ready && rsp_valid) begin
          awaiting = 0;
          if (cur_rd) begin
            for (int k = 3; k >= 0; k--) exp_tx_q.push_back(rsp_rdata[8*k +: 8]);
          end else begin
            exp_tx_q.push_back(8'h4B);
          end
        end
        if (tx_valid && tx_ready) begin
          $display("tx byte=%h", tx_byte);
          got_tx_q.push_back(tx_byte);
          if (exp_tx_q.size() == 0) begin
            fail("tx_unexpected", $sformatf("actual=%h required=none", tx_byte));
          end else begin
            eb = exp_tx_q.pop_front();
            chk("tx_byte", 32'(tx_byte), 32'(eb));
          end
        end
        if (frame_err) ferr_seen++;
        if (rx_ovr) ovr_seen++;
        prev_cv = cmd_valid; prev_cr = cmd_ready; prev_addr = cmd_addr;
        prev_wdata = cmd_wdata; prev_tv = tx_valid; prev_tr = tx_ready; prev_tb = tx_byte;
      end
    end
  end

  // ---------------- driver ----------------
  // All driver tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input int maxgap);
    cmd_t c;
    c.rd = rd; c.addr = addr; c.wdata = wdata;
    exp_cmd_q.push_back(c);
    send_byte(rd ? 8'h52 : 8'h57, $urandom_range(0, maxgap));
    for (int k = 3; k >= 0; k--) send_byte(addr[8*k +: 8], $urandom_range(0, maxgap));
    if (!rd)
      for (int k = 3; k >= 0; k--) send_byte(wdata[8*k +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic send_bad_opcode(input logic [7:0] b);
    send_byte(b, 0);
    exp_ferr++;
    chk("bad_op_frame_err", 32'(frame_err), 32'd1);
    chk("bad_op_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input logic inject);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      if (inject && $urandom_range(0, 7) == 0) begin
        send_byte(8'($urandom), 0);
        exp_ovr++;
        chk("rx_ovr_pulse", 32'(rx_ovr), 32'd1);
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (busy) fail("wait_idle_timeout", "actual=busy required=idle");
    chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
  endtask

  initial begin
    int base_ferr, n;
    logic [7:0] b;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_addr", cmd_addr, 32'd0);
    chk("rst_cmd_read", 32'(cmd_read), 32'd0);
    chk("rst_cmd_wdata", cmd_wdata, 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_rx_ovr", 32'(rx_ovr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reference write frame
    cr_mode = 3;
    got_tx_q.delete();
    send_frame(1'b0, 32'h1001_3000, 32'h0000_0041, 0);
    wait_idle(1'b0);
    chk("w_addr", last_addr, 32'h1001_3000);
    chk("w_read", 32'(last_rd), 32'd0);
    chk("w_wdata", last_wdata, 32'h0000_0041);
    chk("w_tx_count", 32'(got_tx_q.size()), 32'd1);
    if (got_tx_q.size() >= 1) chk("w_tx_ack", 32'(got_tx_q[0]), 32'h4B);

    // reference read frame, sent back to back
    rd_fixed = 1'b1;
    got_tx_q.delete();
    send_frame(1'b1, 32'h1001_3004, 32'h0, 0);
    wait_idle(1'b0);
    chk("r_addr", last_addr, 32'h1001_3004);
    chk("r_read", 32'(last_rd), 32'd1);
    chk("r_wdata", last_wdata, 32'd0);
    chk("r_tx_count", 32'(got_tx_q.size()), 32'd4);
    if (got_tx_q.size() == 4)
      chk("r_tx_bytes", {got_tx_q[0], got_tx_q[1], got_tx_q[2], got_tx_q[3]}, 32'h0000_0011);
    rd_fixed = 1'b0;

    // stalled command, toggling tx_ready
    cr_mode = 1; tr_mode = 1;
    got_tx_q.delete();
    send_frame(1'b1, 32'hCAFE_0010, 32'h0, 1);
    wait_idle(1'b0);
    chk("stall_valid_cycles", 32'(last_cmd_cycles), 32'd6);
    chk("stall_tx_count", 32'(got_tx_q.size()), 32'd4);
    cr_mode = 3; tr_mode = 0;

    // bad opcode: error pulse, no command
    send_bad_opcode(8'h41);
    @(posedge clk); #1;
    chk("bad_op_pulse_end", 32'(frame_err), 32'd0);
    chk("bad_op_no_cmd", 32'(cmd_valid), 32'd0);

    // extra byte while waiting for the response
    rv_mode = 1;
    send_frame(1'b0, 32'h2000_0008, 32'hDEAD_BEEF, 0);
    n = 0;
    while (!rsp_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("reached_rsp", 32'(rsp_ready), 32'd1);
    send_byte(8'h52, 0);
    exp_ovr++;
    chk("rsp_ovr_pulse", 32'(rx_ovr), 32'd1);
    chk("rsp_ovr_still_rsp", 32'(rsp_ready), 32'd1);
    rv_mode = 0;
    wait_idle(1'b0);
    chk("rsp_ovr_last_addr", last_addr, 32'h2000_0008);

`ifdef UART_ICB_BYTE_TIMEOUT_EN
    base_ferr = ferr_seen;
    send_byte(8'h52, 0);
    send_byte(8'h10, 0);
    repeat (95) begin @(posedge clk); #1; end
    chk("tmo_not_yet", 32'(busy), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    exp_ferr++;
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_frame_err", 32'(ferr_seen - base_ferr), 32'd1);
    send_frame(1'b1, 32'h1001_3004, 32'h0, 2);
    wait_idle(1'b0);
    chk("tmo_next_addr", last_addr, 32'h1001_3004);
`else
    base_ferr = ferr_seen;
`endif

    // reset while a command is pending
    cr_mode = 2;
    send_frame(1'b0, 32'h3000_0000, 32'h1234_5678, 0);
    n = 0;
    while (!cmd_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("pre_rst_cmd_valid", 32'(cmd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", cmd_addr, 32'd0);
    exp_cmd_q.delete();
    exp_tx_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cr_mode = 0;
    @(posedge clk); #1;
    send_frame(1'b0, 32'h3000_0004, 32'h8765_4321, 1);
    wait_idle(1'b0);
    chk("post_rst_addr", last_addr, 32'h3000_0004);
    chk("post_rst_wdata", last_wdata, 32'h8765_4321);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      tr_mode = 0;
      if ($urandom_range(0, 4) == 0) begin
        b = 8'($urandom);
        while (b == 8'h52 || b == 8'h57) b = 8'($urandom);
        send_bad_opcode(b);
      end
      send_frame(1'($urandom_range(0, 1)), $urandom, $urandom, 3);
      wait_idle(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_total", 32'(ferr_seen), 32'(exp_ferr));
    chk("rx_ovr_total", 32'(ovr_seen), 32'(exp_ovr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart_icb_master.md
UART_ICB_MASTER -- requirements
Module: uart_icb_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16'd20000, inter-byte timeout in clk cycles (used only with UART_ICB_BYTE_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single block clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Ports: rx_byte  input  8  received UART byte; rx_valid  input  1  one-cycle strobe, byte valid, no backpressure.
REQ-005 Ports: tx_byte  output  8  byte to transmitter; tx_valid  output  1  byte request; tx_ready  input  1  transmitter can accept.
REQ-006 Ports: o_icb_cmd_valid  output  1; o_icb_cmd_ready  input  1; o_icb_cmd_addr  output  32; o_icb_cmd_read  output  1; o_icb_cmd_wdata  output  32.
REQ-007 Ports: o_icb_rsp_valid  input  1; o_icb_rsp_ready  output  1; o_icb_rsp_rdata  input  32.
REQ-008 Ports: busy  output  1  not IDLE; frame_err  output  1  one-cycle error pulse; rx_ovr  output  1  one-cycle dropped-byte pulse.

Function
REQ-009 Frame: opcode byte 0x52 (read) or 0x57 (write), then 4 address bytes MSB first, then 4 wdata bytes MSB first for write only.
REQ-010 FSM states: IDLE, ADDR, WDATA, CMD, RSP, TX; reset state IDLE.
REQ-011 IDLE: rx_valid with 0x52/0x57 latches read flag, clears 2-bit byte counter, goes to ADDR; any other byte stays IDLE and pulses frame_err next cycle.
REQ-012 ADDR: each rx_valid shifts addr = {addr[23:0], rx_byte}; the 4th byte moves to WDATA (write) or CMD (read).
REQ-013 WDATA: same shifting into wdata; the 4th byte moves to CMD.
REQ-014 CMD: o_icb_cmd_valid=1 and addr/read/wdata held stable until the cycle o_icb_cmd_ready=1, then go to RSP; o_icb_cmd_valid never deasserts before acceptance.
REQ-015 Read commands drive o_icb_cmd_wdata = 0.
REQ-016 RSP: o_icb_rsp_ready=1 only in this state; on o_icb_rsp_valid, capture o_icb_rsp_rdata (read) and go to TX; ready and valid in the same cycle as cmd acceptance are not sampled.
REQ-017 TX read: send rdata[31:24], [23:16], [15:8], [7:0]; TX write: send one byte 0x4B.
REQ-018 TX handshake: a byte transfers in a cycle with tx_valid=1 and tx_ready=1; tx_valid and tx_byte are held until transfer; after the last transfer, go to IDLE with tx_valid=0 the next cycle.
REQ-019 rx_valid in CMD, RSP or TX drops the byte, pulses rx_ovr for one cycle, and leaves state unchanged.
REQ-020 busy=1 in every state except IDLE; frame_err and rx_ovr are registered single-cycle pulses.
REQ-021 Back-to-back frames: an opcode byte arriving in the first IDLE cycle after TX is accepted.

Reset
REQ-022 rst_n low asynchronously forces state IDLE and all outputs to 0 (tx_byte, addr, wdata, captured rdata = 0), including mid-transaction.
REQ-023 After reset, a pending bus transaction is abandoned; the integrating SoC resets the bus fabric with the same rst_n.

Configuration
REQ-024 Macro UART_ICB_BYTE_TIMEOUT_EN defined: a 16-bit counter clears on every rx_valid and counts in ADDR/WDATA; at TIMEOUT_CYC it returns the FSM to IDLE and pulses frame_err.
REQ-025 Macro undefined: there is no timeout counter, and ADDR/WDATA wait indefinitely for bytes.
REQ-026 The timeout never applies in CMD, RSP or TX.

Verification
REQ-027 Bytes 57 10 01 30 00 00 00 00 41, cmd_ready=1 -> one cmd with addr 0x10013000, read=0, wdata 0x00000041; after rsp, tx 0x4B.
REQ-028 Bytes 52 10 01 30 04, rsp_rdata 0x00000011 -> read cmd addr 0x10013004; tx 00 00 00 11 in order.
REQ-029 cmd_ready held 0 for 5 cycles, tx_ready toggling -> cmd_valid/addr stable for 6 cycles; no tx byte lost or duplicated.
REQ-030 Opcode 0x41 -> frame_err pulses once, busy stays 0, no ICB cmd; extra rx_valid during RSP -> rx_ovr pulse, frame completes normally.
REQ-031 With UART_ICB_BYTE_TIMEOUT_EN and TIMEOUT_CYC=100: 52 10, then 100 idle cycles -> IDLE and frame_err; a following full frame completes correctly.
REQ-032 rst_n asserted while in CMD -> cmd_valid=0 and busy=0 immediately; the next frame completes normally.
